memory_port_arbiter: RTL and testbench

- Shares the single main-memory block port between the instruction cache (read-only refills) and the data cache (refills and write-backs).
- Sits between both caches and main memory, outside the CPU core.
- Sequences one 128-bit block transaction at a time and alternates grants under contention, so neither cache starves.
- Returns per-requester busywait and readdata, which each cache uses to stall its side of the pipeline.

---
 rtl/memory_port_arbiter.sv | 147 ++++++++++++++
 tb/tb_memory_port_arbiter.sv | 368 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/memory_port_arbiter.sv
// Main-memory port arbiter shared by the instruction and data caches.
// Runs one block transaction at a time. Under contention the requester that
// was not served last wins, so neither cache can starve. Every transaction
// ends with a one-cycle RELEASE, in which both strobes are low. That cycle
// lets memory clear its busywait before the next transaction starts.
//
// Ports:
//   CLK, RESET         clock; synchronous active-high reset
//   i_mem_*            instruction cache side (read-only refills)
//   d_mem_*            data cache side (refills and write-backs)
//   mem_*              main memory block port
//   x_mem_busywait     combinational stall; low for exactly one cycle
//                      (RELEASE) when x's transaction has completed
module memory_port_arbiter #(
  parameter int unsigned ADDR_WIDTH = 28,
  parameter int unsigned DATA_WIDTH = 128
) (
  input  logic                  CLK,
  input  logic                  RESET,
  input  logic                  i_mem_read,
  input  logic [ADDR_WIDTH-1:0] i_mem_address,
  output logic [DATA_WIDTH-1:0] i_mem_readdata,
  output logic                  i_mem_busywait,
  input  logic                  d_mem_read,
  input  logic                  d_mem_write,
  input  logic [ADDR_WIDTH-1:0] d_mem_address,
  input  logic [DATA_WIDTH-1:0] d_mem_writedata,
  output logic [DATA_WIDTH-1:0] d_mem_readdata,
  output logic                  d_mem_busywait,
  output logic                  mem_read,
  output logic                  mem_write,
  output logic [ADDR_WIDTH-1:0] mem_address,
  output logic [DATA_WIDTH-1:0] mem_writedata,
  input  logic [DATA_WIDTH-1:0] mem_readdata,
  input  logic                  mem_busywait
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT_I = 2'd1,
    GRANT_D = 2'd2,
    RELEASE = 2'd3
  } state_e;

  typedef enum logic {
    OWNER_I = 1'b0,
    OWNER_D = 1'b1
  } owner_e;

  state_e                 state_q;
  owner_e                 last_grant_q;
  logic                   first_q;
  logic                   op_write_q;
  logic                   mem_read_q;
  logic                   mem_write_q;
  logic [ADDR_WIDTH-1:0]  mem_address_q;
  logic [DATA_WIDTH-1:0]  mem_writedata_q;
  logic [DATA_WIDTH-1:0]  i_rdata_q;
  logic [DATA_WIDTH-1:0]  d_rdata_q;

  logic i_req;
  logic d_req;
  logic pick_d;
  logic done;

  assign i_req = i_mem_read;
  assign d_req = d_mem_read | d_mem_write;

  // D wins when alone, or when both request and I was served last.
  assign pick_d = d_req & (~i_req | (last_grant_q == OWNER_I));

  // Memory busywait may lag the strobe by a cycle, so the entry cycle never completes.
  assign done = ~first_q & ~mem_busywait;

  // The busywait of the requester just served drops only during RELEASE.
  assign i_mem_busywait = i_req & ~((state_q == RELEASE) & (last_grant_q == OWNER_I));
  assign d_mem_busywait = d_req & ~((state_q == RELEASE) & (last_grant_q == OWNER_D));

  assign mem_read       = mem_read_q;
  assign mem_write      = mem_write_q;
  assign mem_address    = mem_address_q;
  assign mem_writedata  = mem_writedata_q;
  assign i_mem_readdata = i_rdata_q;
  assign d_mem_readdata = d_rdata_q;

  // Arbitration FSM; the memory side is driven only from latched copies of the request.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q         <= IDLE;
      last_grant_q    <= OWNER_I;
      first_q         <= 1'b0;
      op_write_q      <= 1'b0;
      mem_read_q      <= 1'b0;
      mem_write_q     <= 1'b0;
      mem_address_q   <= '0;
      mem_writedata_q <= '0;
      i_rdata_q       <= '0;
      d_rdata_q       <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (pick_d) begin
            // Write takes precedence when read and write are both raised.
            state_q         <= GRANT_D;
            first_q         <= 1'b1;
            op_write_q      <= d_mem_write;
            mem_read_q      <= ~d_mem_write;
            mem_write_q     <= d_mem_write;
            mem_address_q   <= d_mem_address;
            mem_writedata_q <= d_mem_writedata;
          end else if (i_req) begin
            state_q       <= GRANT_I;
            first_q       <= 1'b1;
            op_write_q    <= 1'b0;
            mem_read_q    <= 1'b1;
            mem_write_q   <= 1'b0;
            mem_address_q <= i_mem_address;
          end
        end
        GRANT_I, GRANT_D: begin
          first_q <= 1'b0;
          if (done) begin
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
            state_q     <= RELEASE;
            if (state_q == GRANT_I) begin
              last_grant_q <= OWNER_I;
              i_rdata_q    <= mem_readdata;
            end else begin
              last_grant_q <= OWNER_D;
              if (!op_write_q) begin
                d_rdata_q <= mem_readdata;
              end
            end
          end
        end
        RELEASE: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_memory_port_arbiter.sv
// Bench for memory_port_arbiter. It first runs directed scenarios and then a
// randomized phase. In the random phase, each cache driver pushes the expected
// outcome of every transaction it issues. The monitor pops that entry when the
// requester sees its busywait drop and compares it against what the DUT shows.
module tb_memory_port_arbiter;

  localparam int unsigned AW = 28;
  localparam int unsigned DW = 128;

  logic          CLK = 1'b0;
  logic          RESET;
  logic          i_mem_read;
  logic [AW-1:0] i_mem_address;
  logic [DW-1:0] i_mem_readdata;
  logic          i_mem_busywait;
  logic          d_mem_read;
  logic          d_mem_write;
  logic [AW-1:0] d_mem_address;
  logic [DW-1:0] d_mem_writedata;
  logic [DW-1:0] d_mem_readdata;
  logic          d_mem_busywait;
  logic          mem_read;
  logic          mem_write;
  logic [AW-1:0] mem_address;
  logic [DW-1:0] mem_writedata;
  logic [DW-1:0] mem_readdata;
  logic          mem_busywait;

  always #5 CLK = ~CLK;

  memory_port_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .CLK(CLK), .RESET(RESET),
    .i_mem_read(i_mem_read), .i_mem_address(i_mem_address),
    .i_mem_readdata(i_mem_readdata), .i_mem_busywait(i_mem_busywait),
    .d_mem_read(d_mem_read), .d_mem_write(d_mem_write),
    .d_mem_address(d_mem_address), .d_mem_writedata(d_mem_writedata),
    .d_mem_readdata(d_mem_readdata), .d_mem_busywait(d_mem_busywait),
    .mem_read(mem_read), .mem_write(mem_write), .mem_address(mem_address),
    .mem_writedata(mem_writedata), .mem_readdata(mem_readdata),
    .mem_busywait(mem_busywait)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic fail(input string msg);
    n_checks++;
    n_errors++;
    $display("FAIL %s", msg);
  endtask

  function automatic logic [DW-1:0] init_val(input int a);
    if (a == 16) return 128'hDEADBEEF_01234567_89ABCDEF_0BADF00D;
    return {4{32'hC0DE_0000 + 32'(a)}};
  endfunction

  // Main memory model: busy for cur_delay strobe cycles, combinational read data.
  logic [DW-1:0] store [128];
  bit            mem_ready   = 1'b0;
  int            cnt         = 0;
  int            cur_delay   = 0;
  int            fixed_delay = 0;

  assign mem_busywait = (mem_read || mem_write) && (cnt < cur_delay);
  assign mem_readdata = store[mem_address[6:0]];

  always @(posedge CLK) begin
    if (!mem_ready) begin
      for (int i = 0; i < 128; i++) store[i] <= init_val(i);
      mem_ready <= 1'b1;
    end else if (mem_read || mem_write) begin
      cnt <= cnt + 1;
      if (mem_write && !mem_busywait) store[mem_address[6:0]] <= mem_writedata;
    end else begin
      cnt       <= 0;
      cur_delay <= (fixed_delay >= 0) ? fixed_delay : int'($urandom_range(0, 4));
    end
  end

  // Reference model state and scoreboard queues.
  typedef struct packed {
    logic [6:0]    addr;
    logic          wr;
    logic [DW-1:0] wdata;
    logic [DW-1:0] rdata;
  } txn_t;

  logic [DW-1:0] ref_mem [128];
  txn_t          i_q[$];
  txn_t          d_q[$];
  bit            sb_en = 1'b0;
  logic [DW-1:0] d_hold;
  logic [AW-1:0] cap_addr;
  logic          cap_wr;
  logic [DW-1:0] cap_wdata;

  // Monitor: bus invariants every cycle; scoreboard pops on each completion.
  always @(negedge CLK) begin
    txn_t e;
    if (mem_read || mem_write) begin
      cap_addr  = mem_address;
      cap_wr    = mem_write;
      cap_wdata = mem_writedata;
    end
    if (!RESET) begin
      check("strobe_excl", DW'(mem_read && mem_write), DW'(0));
      if ((i_mem_read && !i_mem_busywait) || ((d_mem_read || d_mem_write) && !d_mem_busywait))
        check("strobe_in_release", DW'(mem_read || mem_write), DW'(0));
      if (sb_en && i_mem_read && !i_mem_busywait) begin
        if (i_q.size() == 0) fail("sb_i unexpected completion");
        else begin
          e = i_q.pop_front();
          check("sb_i_addr", DW'(cap_addr), DW'(e.addr));
          check("sb_i_op", DW'(cap_wr), DW'(1'b0));
          check("sb_i_rdata", i_mem_readdata, e.rdata);
        end
      end
      if (sb_en && (d_mem_read || d_mem_write) && !d_mem_busywait) begin
        if (d_q.size() == 0) fail("sb_d unexpected completion");
        else begin
          e = d_q.pop_front();
          check("sb_d_addr", DW'(cap_addr), DW'(e.addr));
          check("sb_d_op", DW'(cap_wr), DW'(e.wr));
          if (e.wr) begin
            check("sb_d_wdata", cap_wdata, e.wdata);
            check("sb_d_rdata_hold", d_mem_readdata, d_hold);
          end else begin
            check("sb_d_rdata", d_mem_readdata, e.rdata);
            d_hold = e.rdata;
          end
        end
      end
    end
  end

  // Hold the current request until busywait drops, then release it for a random gap.
  task automatic wait_done_i();
    int w = 0;
    do begin @(negedge CLK); #1; w++; end while (i_mem_busywait && w < 200);
    if (i_mem_busywait) fail("drv_i timeout waiting for completion");
    i_mem_read = 1'b0;
    repeat ($urandom_range(0, 2)) begin @(negedge CLK); #1; end
  endtask

  task automatic drive_i(input int n);
    for (int k = 0; k < n; k++) begin
      txn_t e;
      logic [6:0] a;
      a = 7'($urandom_range(0, 63));
      e.addr = a; e.wr = 1'b0; e.wdata = '0; e.rdata = ref_mem[a];
      i_q.push_back(e);
      i_mem_address = AW'(a);
      i_mem_read    = 1'b1;
      wait_done_i();
    end
  endtask

  task automatic drive_d(input int n);
    for (int k = 0; k < n; k++) begin
      txn_t e;
      logic [6:0] a;
      int op;
      int w;
      a  = 7'(64 + $urandom_range(0, 63));
      op = int'($urandom_range(0, 2));
      e.addr  = a;
      e.wr    = (op != 0);
      e.wdata = {$urandom, $urandom, $urandom, $urandom};
      e.rdata = e.wr ? '0 : ref_mem[a];
      if (e.wr) ref_mem[a] = e.wdata;
      d_q.push_back(e);
      d_mem_address   = AW'(a);
      d_mem_writedata = e.wdata;
      d_mem_read      = (op != 1);
      d_mem_write     = (op != 0);
      w = 0;
      do begin @(negedge CLK); #1; w++; end while (d_mem_busywait && w < 200);
      if (d_mem_busywait) fail("drv_d timeout waiting for completion");
      d_mem_read  = 1'b0;
      d_mem_write = 1'b0;
      repeat ($urandom_range(0, 2)) begin @(negedge CLK); #1; end
    end
  endtask

  // Serve pending I and D requests to completion, recording completion cycles and the first bus op.
  task automatic serve_both(input logic [DW-1:0] exp_i, input string tag,
                            output int od, output int oi, output int fc,
                            output logic fw, output logic [AW-1:0] fa, output logic [DW-1:0] fwd);
    od = -1; oi = -1; fc = -1; fw = 1'b0; fa = '0; fwd = '0;
    for (int c = 1; c <= 40 && (i_mem_read || d_mem_read || d_mem_write); c++) begin
      logic di;
      logic dd;
      @(negedge CLK);
      if (fc < 0 && (mem_read || mem_write)) begin
        fc = c; fw = mem_write; fa = mem_address; fwd = mem_writedata;
      end
      di = i_mem_read && !i_mem_busywait;
      dd = (d_mem_read || d_mem_write) && !d_mem_busywait;
      if (di) begin oi = c; check({tag, "_i_rdata"}, i_mem_readdata, exp_i); end
      if (dd) od = c;
      #1;
      if (di) i_mem_read = 1'b0;
      if (dd) begin d_mem_read = 1'b0; d_mem_write = 1'b0; end
    end
    if (i_mem_read || d_mem_read || d_mem_write) fail({tag, " timeout serving requests"});
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int od, oi, fc, n, lows, low_at, rises, w;
    logic fw, prev;
    logic [AW-1:0] fa;
    logic [DW-1:0] fwd;
    logic [DW-1:0] w1;
    logic seq [4];

    for (int i = 0; i < 128; i++) ref_mem[i] = init_val(i);

    // Reset held two cycles with both requests (tie set up) active.
    RESET = 1'b1;
    i_mem_read = 1'b1; i_mem_address = AW'(28'h30);
    d_mem_read = 1'b0; d_mem_write = 1'b1; d_mem_address = AW'(28'h20);
    d_mem_writedata = {16{8'hA5}};
    fixed_delay = 0;
    @(negedge CLK);
    @(negedge CLK);
    check("rst_mem_read", DW'(mem_read), DW'(0));
    check("rst_mem_write", DW'(mem_write), DW'(0));
    check("rst_mem_address", DW'(mem_address), DW'(0));
    check("rst_mem_writedata", mem_writedata, DW'(0));
    check("rst_i_rdata", i_mem_readdata, DW'(0));
    check("rst_d_rdata", d_mem_readdata, DW'(0));
    check("rst_i_busy", DW'(i_mem_busywait), DW'(1));
    check("rst_d_busy", DW'(d_mem_busywait), DW'(1));
    #1 RESET = 1'b0;
    #1 check("rst_release_no_strobe", DW'(mem_read || mem_write), DW'(0));

    // Tie after reset: D write first, then I read.
    serve_both(ref_mem[7'h30], "tie", od, oi, fc, fw, fa, fwd);
    check("tie_first_cycle", DW'(fc), DW'(1));
    check("tie_first_is_write", DW'(fw), DW'(1));
    check("tie_first_addr", DW'(fa), DW'(28'h20));
    check("tie_first_wdata", fwd, {16{8'hA5}});
    check("tie_d_done_cycle", DW'(od), DW'(3));
    check("tie_i_done_cycle", DW'(oi), DW'(7));
    check("tie_d_rdata_zero", d_mem_readdata, DW'(0));
    ref_mem[7'h20] = {16{8'hA5}};
    check("tie_mem_written", store[7'h20], ref_mem[7'h20]);

    // Lone I read with 5 busy cycles.
    repeat (2) @(negedge CLK);
    #1 fixed_delay = 5; i_mem_address = AW'(28'h10); i_mem_read = 1'b1;
    #1 check("lone_busy_same_cycle", DW'(i_mem_busywait), DW'(1));
    lows = 0; low_at = -1;
    for (int k = 1; k <= 7; k++) begin
      @(negedge CLK);
      if (k <= 6) begin
        check("lone_strobe", DW'(mem_read), DW'(1));
        check("lone_addr", DW'(mem_address), DW'(28'h10));
      end else check("lone_strobe_off", DW'(mem_read), DW'(0));
      if (!i_mem_busywait) begin lows++; low_at = k; end
    end
    check("lone_busy_low_count", DW'(lows), DW'(1));
    check("lone_busy_low_cycle", DW'(low_at), DW'(7));
    check("lone_rdata", i_mem_readdata, ref_mem[7'h10]);
    #1 i_mem_read = 1'b0;

    // Sustained contention over four transactions.
    repeat (2) @(negedge CLK);
    #1 fixed_delay = 1;
    d_mem_read = 1'b1; d_mem_address = AW'(28'h20);
    i_mem_read = 1'b1; i_mem_address = AW'(28'h10);
    n = 0;
    for (int c = 0; c < 60 && n < 4; c++) begin
      @(negedge CLK);
      if (d_mem_read && !d_mem_busywait) begin
        check("cont_d_rdata", d_mem_readdata, ref_mem[7'h20]);
        seq[n] = 1'b1; n++;
      end else if (i_mem_read && !i_mem_busywait) begin
        check("cont_i_rdata", i_mem_readdata, ref_mem[7'h10]);
        seq[n] = 1'b0; n++;
      end
    end
    #1 d_mem_read = 1'b0; i_mem_read = 1'b0;
    if (n < 4) fail("cont timeout before four completions");
    else begin
      check("cont_order_0", DW'(seq[0]), DW'(1));
      check("cont_order_1", DW'(seq[1]), DW'(0));
      check("cont_order_2", DW'(seq[2]), DW'(1));
      check("cont_order_3", DW'(seq[3]), DW'(0));
    end

    // Reset in the middle of a D write while memory is still busy.
    repeat (2) @(negedge CLK);
    w1 = 128'h1111_2222_3333_4444_5555_6666_7777_8888;
    #1 fixed_delay = 10; d_mem_write = 1'b1; d_mem_address = AW'(28'h40); d_mem_writedata = w1;
    w = 0;
    do begin @(negedge CLK); w++; end while (!mem_write && w < 10);
    check("mid_grant_seen", DW'(mem_write), DW'(1));
    @(negedge CLK);
    @(negedge CLK);
    #1 RESET = 1'b1; i_mem_read = 1'b1; i_mem_address = AW'(28'h30);
    @(negedge CLK);
    check("mid_rst_write_off", DW'(mem_write), DW'(0));
    check("mid_rst_read_off", DW'(mem_read), DW'(0));
    check("mid_rst_i_rdata", i_mem_readdata, DW'(0));
    check("mid_rst_d_rdata", d_mem_readdata, DW'(0));
    check("mid_rst_d_busy", DW'(d_mem_busywait), DW'(1));
    check("mid_rst_not_written", store[7'h40], ref_mem[7'h40]);
    #1 RESET = 1'b0; fixed_delay = 0;
    serve_both(ref_mem[7'h30], "mid", od, oi, fc, fw, fa, fwd);
    check("mid_first_is_write", DW'(fw), DW'(1));
    check("mid_first_addr", DW'(fa), DW'(28'h40));
    check("mid_d_done_cycle", DW'(od), DW'(3));
    check("mid_i_done_cycle", DW'(oi), DW'(7));
    ref_mem[7'h40] = w1;
    check("mid_mem_written", store[7'h40], ref_mem[7'h40]);

    // Withdrawal two cycles into GRANT_D.
    repeat (2) @(negedge CLK);
    #1 fixed_delay = 5; d_mem_read = 1'b1; d_mem_address = AW'(28'h41);
    @(negedge CLK);
    check("wd_strobe", DW'(mem_read), DW'(1));
    @(negedge CLK);
    #1 d_mem_read = 1'b0;
    rises = 0; prev = 1'b1;
    for (int k = 0; k < 12; k++) begin
      @(negedge CLK);
      check("wd_busy_low", DW'(d_mem_busywait), DW'(0));
      if ((mem_read || mem_write) && !prev) rises++;
      prev = mem_read || mem_write;
    end
    check("wd_no_new_txn", DW'(rises), DW'(0));
    check("wd_strobe_done", DW'(mem_read), DW'(0));
    check("wd_rdata", d_mem_readdata, ref_mem[7'h41]);

    // Randomized traffic against the scoreboard.
    d_hold = ref_mem[7'h41];
    fixed_delay = -1;
    sb_en = 1'b1;
    #1;
    fork
      drive_i(40);
      drive_d(40);
    join
    @(negedge CLK);
    sb_en = 1'b0;
    check("sb_i_drained", DW'(i_q.size()), DW'(0));
    check("sb_d_drained", DW'(d_q.size()), DW'(0));

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
